// File: rtl/seq_divider_16bit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : seq_divider_16bit_pkg                                         |
// | Purpose  : Shared width default, FSM state encoding and counter sizing   |
// |            for the sequential restoring divider.                         |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
package seq_divider_16bit_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_16bit_cla_sub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : cla_sub_16bit                                                 |
// | Purpose  : Combinational subtractor diff = a - b, built as a + ~b + 1    |
// |            from 4-bit carry-lookahead groups chained through group P/G.  |
// | Ports    : a, b    - operands (WIDTH bits)                               |
// |            diff    - a - b modulo 2^WIDTH                                |
// |            cout    - carry out; borrow = ~cout                           |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module cla_sub_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] bn;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [NGRP:0]    gc;   // carry into each 4-bit group

  assign bn    = ~b;
  assign p     = a ^ bn;
  assign g     = a & bn;
  assign gc[0] = 1'b1;    // +1 of the two's complement

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    logic [3:0] pp;
    logic [3:0] gg;
    logic [3:0] c;
    logic       grp_p;
    logic       grp_g;

    assign pp   = p[4*k +: 4];
    assign gg   = g[4*k +: 4];
    assign c[0] = gc[k];
    assign c[1] = gg[0] | (pp[0] & c[0]);
    assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
    assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & c[0]);

    assign grp_p = &pp;
    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);

    assign gc[k+1]      = grp_g | (grp_p & gc[k]);
    assign diff[4*k +: 4] = pp ^ c;
  end

  assign cout = gc[NGRP];

endmodule
`default_nettype wire

// File: rtl/seq_divider_16bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : seq_divider_16bit                                             |
// | Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per  |
// |            clock, start/busy/done handshake.                             |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            start, dividend, divisor - request and operands               |
// |            busy        - operation in flight                             |
// |            done        - one-cycle result-valid pulse                    |
// |            quotient, remainder, div_by_zero - held results               |
// | Revision : 1.0 - initial release                                         |
// ----------------------------------------------------------------------------
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    cnt;
  logic             dbz_reg;

  logic             msb;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             take;
  logic             last_iter;
  logic             divisor_zero;

  assign msb          = r_reg[WIDTH-1];
  assign rs           = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  // A set msb means the shifted remainder is really WIDTH+1 bits wide and is
  // therefore larger than any divisor, so the subtraction is always taken.
  assign take         = msb | cout;
  assign last_iter    = (cnt == CW'(WIDTH - 1));
  assign divisor_zero = (divisor == '0);

  cla_sub_16bit #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a    (rs),
    .b    (dvs_reg),
    .diff (diff),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = divisor_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = divisor_zero ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      r_reg   <= '0;
      dvs_reg <= '0;
      cnt     <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dvs_reg <= divisor;
            cnt     <= '0;
            if (divisor_zero) begin
              q_reg   <= '1;
              r_reg   <= dividend;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= dividend;
              r_reg   <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          q_reg <= {q_reg[WIDTH-2:0], take};
          r_reg <= take ? diff : rs;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule
`default_nettype wire
